// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet assembler with saturating absolute X/Y tracking,
// button/wheel capture, header resync, inter-byte timeout and overflow rejection.
module ps2_mouse_tracker #(
    parameter int unsigned COORD_W     = 8,
    parameter int unsigned X_MAX       = 99,
    parameter int unsigned Y_MAX       = 99,
    parameter int unsigned WHEEL_EN    = 0,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [7:0]         rx_data,
    input  logic               rx_vld,
    input  logic               clr,
    output logic               pkt_vld,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos,
    output logic [3:0]         wheel_delta,
    output logic               left_button,
    output logic               right_button,
    output logic               middle_button,
    output logic               seq_error,
    output logic [2:0]         pkt_cnt
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    // Wide enough for pos + 9-bit signed delta without wrap
    localparam int unsigned SUM_W = (COORD_W + 2 > 10) ? COORD_W + 2 : 10;

    typedef enum logic [1:0] {S_B0, S_B1, S_B2, S_B3} state_t;

    state_t             state_q, state_d;
    // Header without the always-one bit 3: {y_ovf, x_ovf, y_sign, x_sign, mid, right, left}
    logic [6:0]         hdr_q, hdr_d;
    logic [7:0]         b1_q, b1_d;
    logic [7:0]         b2_q, b2_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               pkt_vld_q, pkt_vld_d;
    logic [COORD_W-1:0] x_pos_q, x_pos_d;
    logic [COORD_W-1:0] y_pos_q, y_pos_d;
    logic [3:0]         wheel_q, wheel_d;
    logic [2:0]         btn_q, btn_d;
    logic               seq_error_q, seq_error_d;
    logic [2:0]         pkt_cnt_q, pkt_cnt_d;

    logic               hdr_err, to_hit, fin;
    logic [7:0]         y_byte;
    logic [3:0]         wheel_nib;
    logic signed [SUM_W-1:0] dx_s, dy_s, x_sum, y_sum;
    logic [COORD_W-1:0] x_new, y_new;

    // Saturate a signed sum into 0..max
    function automatic logic [COORD_W-1:0] clamp_pos(input logic signed [SUM_W-1:0] s,
                                                     input logic [COORD_W-1:0] max_v);
        logic [COORD_W-1:0] r;
        if (s[SUM_W-1]) begin
            r = '0;
        end else if (s > $signed({{(SUM_W-COORD_W){1'b0}}, max_v})) begin
            r = max_v;
        end else begin
            r = s[COORD_W-1:0];
        end
        return r;
    endfunction

    // Byte-assembly FSM next state, timeout counter and byte latches
    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        b1_d     = b1_q;
        b2_d     = b2_q;
        to_cnt_d = '0;
        hdr_err  = 1'b0;
        to_hit   = 1'b0;
        fin      = 1'b0;

        if (state_q != S_B0 && !rx_vld) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                to_hit = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        case (state_q)
            S_B0: begin
                if (rx_vld) begin
                    if (rx_data[3]) begin
                        hdr_d   = {rx_data[7:4], rx_data[2:0]};
                        state_d = S_B1;
                    end else begin
                        hdr_err = 1'b1;
                    end
                end
            end
            S_B1: begin
                if (rx_vld) begin
                    b1_d    = rx_data;
                    state_d = S_B2;
                end else if (to_hit) begin
                    state_d = S_B0;
                end
            end
            S_B2: begin
                if (rx_vld) begin
                    b2_d = rx_data;
                    if (WHEEL_EN != 0) begin
                        state_d = S_B3;
                    end else begin
                        fin     = 1'b1;
                        state_d = S_B0;
                    end
                end else if (to_hit) begin
                    state_d = S_B0;
                end
            end
            S_B3: begin
                if (rx_vld) begin
                    fin     = 1'b1;
                    state_d = S_B0;
                end else if (to_hit) begin
                    state_d = S_B0;
                end
            end
            default: state_d = S_B0;
        endcase
    end

    // Delta arithmetic; the final byte is still on rx_data when fin is high
    always_comb begin
        y_byte    = (state_q == S_B2) ? rx_data : b2_q;
        wheel_nib = (WHEEL_EN != 0) ? rx_data[3:0] : 4'd0;
        dx_s      = {{(SUM_W-8){hdr_q[3]}}, b1_q};
        dy_s      = {{(SUM_W-8){hdr_q[4]}}, y_byte};
        x_sum     = $signed({{(SUM_W-COORD_W){1'b0}}, x_pos_q}) + dx_s;
        y_sum     = $signed({{(SUM_W-COORD_W){1'b0}}, y_pos_q}) + dy_s;
        x_new     = clamp_pos(x_sum, COORD_W'(X_MAX));
        y_new     = clamp_pos(y_sum, COORD_W'(Y_MAX));
    end

    // Output register next values: packet apply, then clr override
    always_comb begin
        pkt_vld_d   = 1'b0;
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        wheel_d     = wheel_q;
        btn_d       = btn_q;
        pkt_cnt_d   = pkt_cnt_q;
        seq_error_d = seq_error_q | hdr_err | to_hit;

        if (fin) begin
            pkt_vld_d = 1'b1;
            pkt_cnt_d = pkt_cnt_q + 3'd1;
            btn_d     = hdr_q[2:0];
            wheel_d   = wheel_nib;
            if (!hdr_q[5]) begin
                x_pos_d = x_new;
            end
            if (!hdr_q[6]) begin
                y_pos_d = y_new;
            end
        end

        if (clr) begin
            x_pos_d     = '0;
            y_pos_d     = '0;
            wheel_d     = 4'd0;
            seq_error_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_B0;
            hdr_q       <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            to_cnt_q    <= '0;
            pkt_vld_q   <= 1'b0;
            x_pos_q     <= '0;
            y_pos_q     <= '0;
            wheel_q     <= '0;
            btn_q       <= '0;
            seq_error_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            to_cnt_q    <= to_cnt_d;
            pkt_vld_q   <= pkt_vld_d;
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
            wheel_q     <= wheel_d;
            btn_q       <= btn_d;
            seq_error_q <= seq_error_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign pkt_vld       = pkt_vld_q;
    assign x_pos         = x_pos_q;
    assign y_pos         = y_pos_q;
    assign wheel_delta   = wheel_q;
    assign left_button   = btn_q[0];
    assign right_button  = btn_q[1];
    assign middle_button = btn_q[2];
    assign seq_error     = seq_error_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule
